// File: rtl/shift_unit.sv
// Shift/rotate register with a manual single-step mode and a counted burst mode.
// Loads override everything; a burst runs its latched op for len edges, then pulses done.
module shift_unit #(
    parameter int WIDTH = 16,
    parameter int LENW  = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ld,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic             sd,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic [LENW-1:0]  len,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_SHL_SD = 3'b001;
    localparam logic [2:0] OP_SHR_SD = 3'b010;
    localparam logic [2:0] OP_ROTL   = 3'b011;
    localparam logic [2:0] OP_ROTR   = 3'b100;
    localparam logic [2:0] OP_ASR    = 3'b101;
    localparam logic [2:0] OP_SHL_0  = 3'b110;
    localparam logic [2:0] OP_SHR_0  = 3'b111;

    localparam logic [LENW-1:0] CNT_ONE = LENW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               sout_q, sout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [LENW-1:0]    cnt_q, cnt_d;
    logic [2:0]         opr_q, opr_d;

    logic [2:0]         step_op;
    logic [WIDTH-1:0]   step_val;
    logic               step_out;

    // One step of the selected op; a burst uses its latched op, manual mode the live one.
    always_comb begin
        step_op  = (state_q == RUN) ? opr_q : op;
        step_val = shreg_q;
        step_out = sout_q;
        case (step_op)
            OP_SHL_SD: begin
                step_val = {shreg_q[WIDTH-2:0], sd};
                step_out = shreg_q[WIDTH-1];
            end
            OP_SHR_SD: begin
                step_val = {sd, shreg_q[WIDTH-1:1]};
                step_out = shreg_q[0];
            end
            OP_ROTL: begin
                step_val = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
                step_out = shreg_q[WIDTH-1];
            end
            OP_ROTR: begin
                step_val = {shreg_q[0], shreg_q[WIDTH-1:1]};
                step_out = shreg_q[0];
            end
            OP_ASR: begin
                step_val = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
                step_out = shreg_q[0];
            end
            OP_SHL_0: begin
                step_val = {shreg_q[WIDTH-2:0], 1'b0};
                step_out = shreg_q[WIDTH-1];
            end
            OP_SHR_0: begin
                step_val = {1'b0, shreg_q[WIDTH-1:1]};
                step_out = shreg_q[0];
            end
            default: begin
                step_val = shreg_q;
                step_out = sout_q;
            end
        endcase
    end

    // Priority: load, burst step, burst accept, manual step, hold.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        sout_d  = sout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        opr_d   = opr_q;

        if (ld) begin
            shreg_d = d;
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            shreg_d = step_val;
            sout_d  = step_out;
            cnt_d   = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end else if (start) begin
            if (len != '0) begin
                opr_d   = op;
                cnt_d   = len;
                busy_d  = 1'b1;
                state_d = RUN;
            end else begin
                done_d  = 1'b1;
            end
        end else if (en) begin
            shreg_d = step_val;
            sout_d  = step_out;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            opr_q   <= OP_HOLD;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            opr_q   <= opr_d;
        end
    end

    assign q    = shreg_q;
    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_shift_unit.sv
// Randomised and directed bench for shift_unit (WIDTH=8): an arithmetic reference
// model feeds a scoreboard queue that a negedge monitor drains and compares.
module tb_shift_unit;

    localparam int W  = 8;
    localparam int LW = 7;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ld, en, sd, start;
    logic [2:0]    op;
    logic [W-1:0]  d;
    logic [LW-1:0] len;
    logic [W-1:0]  q;
    logic          sout, busy, done;

    int tests = 0;
    int fails = 0;

    logic [10:0] sb[$];
    logic [10:0] mon_exp, mon_got;

    // Reference model state: rem is the number of burst steps still to run.
    int m_q, m_sout, m_rem, m_op, m_done;

    always #5 clk = ~clk;

    shift_unit #(.WIDTH(W), .LENW(LW)) dut (
        .clk(clk), .reset_n(reset_n), .ld(ld), .en(en), .op(op), .sd(sd),
        .d(d), .start(start), .len(len), .q(q), .sout(sout), .busy(busy), .done(done)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void model_step(input int o, input int fill);
        int hi, lo, full, top;
        full = 2 ** W;
        top  = 2 ** (W - 1);
        hi   = m_q / top;
        lo   = m_q % 2;
        case (o)
            1: begin m_sout = hi; m_q = (m_q * 2) % full + fill; end
            2: begin m_sout = lo; m_q = m_q / 2 + fill * top;    end
            3: begin m_sout = hi; m_q = (m_q * 2) % full + hi;   end
            4: begin m_sout = lo; m_q = m_q / 2 + lo * top;      end
            5: begin m_sout = lo; m_q = m_q / 2 + hi * top;      end
            6: begin m_sout = hi; m_q = (m_q * 2) % full;        end
            7: begin m_sout = lo; m_q = m_q / 2;                 end
            default: ;
        endcase
    endfunction

    function automatic void model_edge(input int i_ld, input int i_en, input int i_op,
                                       input int i_sd, input int i_d, input int i_start,
                                       input int i_len);
        m_done = 0;
        if (i_ld != 0) begin
            m_q   = i_d;
            m_rem = 0;
        end else if (m_rem > 0) begin
            model_step(m_op, i_sd);
            m_rem = m_rem - 1;
            if (m_rem == 0) m_done = 1;
        end else if (i_start != 0) begin
            if (i_len > 0) begin
                m_op  = i_op;
                m_rem = i_len;
            end else begin
                m_done = 1;
            end
        end else if (i_en != 0) begin
            model_step(i_op, i_sd);
        end
    endfunction

    task automatic cyc(input logic i_ld, input logic i_en, input logic [2:0] i_op,
                       input logic i_sd, input logic [W-1:0] i_d, input logic i_start,
                       input logic [LW-1:0] i_len);
        logic [10:0] e;
        ld = i_ld; en = i_en; op = i_op; sd = i_sd; d = i_d; start = i_start; len = i_len;
        model_edge(int'(i_ld), int'(i_en), int'(i_op), int'(i_sd), int'(i_d),
                   int'(i_start), int'(i_len));
        @(posedge clk);
        #1;
        e = {W'(m_q), 1'(m_sout), (m_rem > 0), 1'(m_done)};
        sb.push_back(e);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 3'd0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic ldv(input logic [W-1:0] v);
        cyc(1'b1, 1'b0, 3'd0, 1'b0, v, 1'b0, '0);
    endtask

    // Asynchronous reset asserted and released between edges, after the scoreboard drains.
    task automatic rst_pulse(input string tag);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check({tag, "_q"},    32'(q),    32'h0);
        check({tag, "_sout"}, 32'(sout), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        m_q = 0; m_sout = 0; m_rem = 0; m_done = 0; m_op = 0;
        #1;
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_exp = sb.pop_front();
            mon_got = {q, sout, busy, done};
            tests++;
            if (mon_got !== mon_exp) begin
                fails++;
                $display("FAIL scoreboard: got q=%h sout=%b busy=%b done=%b, expected q=%h sout=%b busy=%b done=%b",
                         mon_got[10:3], mon_got[2], mon_got[1], mon_got[0],
                         mon_exp[10:3], mon_exp[2], mon_exp[1], mon_exp[0]);
            end else begin
                $display("[MON] t=%0t q=%h sout=%b busy=%b done=%b", $time, q, sout, busy, done);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        ld = 0; en = 0; sd = 0; start = 0; op = '0; d = '0; len = '0;
        m_q = 0; m_sout = 0; m_rem = 0; m_op = 0; m_done = 0;
        #2;
        check("reset_q",    32'(q),    32'h0);
        check("reset_sout", 32'(sout), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Shift right with fill 1
        ldv(8'hA5);
        cyc(1'b0, 1'b1, 3'b010, 1'b1, '0, 1'b0, '0);
        check("shr_sd_q",    32'(q),    32'hD2);
        check("shr_sd_sout", 32'(sout), 32'h1);

        // Arithmetic shift right, rotate right
        ldv(8'h81);
        cyc(1'b0, 1'b1, 3'b101, 1'b0, '0, 1'b0, '0);
        check("asr_q",    32'(q),    32'hC0);
        check("asr_sout", 32'(sout), 32'h1);
        ldv(8'h01);
        cyc(1'b0, 1'b1, 3'b100, 1'b0, '0, 1'b0, '0);
        check("rotr_q",    32'(q),    32'h80);
        check("rotr_sout", 32'(sout), 32'h1);

        // Burst rotl len=3; start and en during the burst must be ignored
        ldv(8'h01);
        cyc(1'b0, 1'b0, 3'b011, 1'b0, '0, 1'b1, 7'd3);
        check("burst3_accept_q",    32'(q),    32'h01);
        check("burst3_accept_busy", 32'(busy), 32'h1);
        cyc(1'b0, 1'b1, 3'b001, 1'b1, '0, 1'b1, 7'd7);
        check("burst3_s1_q", 32'(q), 32'h02);
        cyc(1'b0, 1'b1, 3'b001, 1'b1, '0, 1'b1, 7'd7);
        check("burst3_s2_q", 32'(q), 32'h04);
        cyc(1'b0, 1'b1, 3'b001, 1'b1, '0, 1'b1, 7'd7);
        check("burst3_s3_q",    32'(q),    32'h08);
        check("burst3_s3_busy", 32'(busy), 32'h0);
        check("burst3_s3_done", 32'(done), 32'h1);
        idle();
        check("burst3_after_done", 32'(done), 32'h0);

        // Burst longer than the register
        ldv(8'hFF);
        cyc(1'b0, 1'b0, 3'b110, 1'b0, '0, 1'b1, 7'd10);
        repeat (8) idle();
        check("burst10_q",    32'(q),    32'h00);
        check("burst10_busy", 32'(busy), 32'h1);
        repeat (2) idle();
        check("burst10_busy_end", 32'(busy), 32'h0);
        check("burst10_done",     32'(done), 32'h1);

        // Load aborts a burst; zero-length start only pulses done
        ldv(8'h96);
        cyc(1'b0, 1'b0, 3'b100, 1'b0, '0, 1'b1, 7'd5);
        idle();
        cyc(1'b1, 1'b0, 3'b000, 1'b0, 8'h3C, 1'b0, '0);
        check("abort_q",    32'(q),    32'h3C);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        idle();
        check("abort_no_done", 32'(done), 32'h0);
        cyc(1'b0, 1'b0, 3'b011, 1'b0, '0, 1'b1, 7'd0);
        check("len0_done", 32'(done), 32'h1);
        check("len0_q",    32'(q),    32'h3C);
        check("len0_busy", 32'(busy), 32'h0);
        idle();
        check("len0_done_clear", 32'(done), 32'h0);

        // start and en together in IDLE: start wins
        cyc(1'b0, 1'b1, 3'b001, 1'b1, '0, 1'b1, 7'd2);
        check("start_wins_q", 32'(q), 32'h3C);
        repeat (3) idle();

        // Hold-op burst and a full-length rotate burst
        ldv(8'h6B);
        cyc(1'b0, 1'b0, 3'b000, 1'b0, '0, 1'b1, 7'd4);
        repeat (5) idle();
        cyc(1'b0, 1'b0, 3'b011, 1'b0, '0, 1'b1, 7'd127);
        repeat (128) idle();

        // Reset mid-burst
        ldv(8'h5A);
        cyc(1'b0, 1'b0, 3'b001, 1'b1, '0, 1'b1, 7'd6);
        repeat (2) idle();
        rst_pulse("midburst_rst");
        repeat (8) idle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 15) == 0,
                1'($urandom),
                3'($urandom),
                1'($urandom),
                W'($urandom),
                $urandom_range(0, 5) == 0,
                LW'($urandom_range(0, 20)));
            if ($urandom_range(0, 99) == 0) rst_pulse("rand_rst");
        end
        repeat (2) idle();

        repeat (4) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameter: WIDTH, 16, register width in bits; legal range 2..64.
REQ-002 Parameter: LENW, 7, width of burst-length port; bursts of 0..2^LENW-1 steps.
REQ-003 Port: clk  input  1  rising-edge clock, sole clock of the block.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: ld  input  1  parallel load strobe.
REQ-006 Port: en  input  1  single-step enable (manual mode).
REQ-007 Port: op  input  3  shift operation select (REQ-012).
REQ-008 Port: sd  input  1  serial fill bit.
REQ-009 Port: d  input  WIDTH  parallel load data.
REQ-010 Port: start  input  1  burst request; len and op sampled with it.
REQ-011 Port: len  input  LENW  burst step count.
REQ-011a Ports (outputs): q WIDTH register contents; sout 1 last bit shifted/rotated out; busy 1 burst in progress; done 1 one-cycle burst-complete pulse. All registered.

Function
REQ-012 op encoding, one step: 000 hold; 001 shl fill sd; 010 shr fill sd; 011 rotl; 100 rotr; 101 arithmetic shr (MSB replicated); 110 shl fill 0; 111 shr fill 0.
REQ-013 On each step sout SHALL take the bit leaving q (q[WIDTH-1] for left ops, q[0] for right ops); op 000 and loads leave sout unchanged.
REQ-014 Per-edge priority: ld > active burst step > start accept > en step > hold.
REQ-015 ld=1: q<=d next edge, regardless of other inputs; if busy, burst aborts: busy<=0, done stays 0, counter cleared.
REQ-016 Manual step: idle, ld=0, start=0, en=1 -> one op step per edge; en=0 -> q holds.
REQ-017 FSM states IDLE, RUN. IDLE->RUN on edge with start=1, ld=0, len!=0: latch op into op_r, cnt<=len, busy<=1; no shift on accept edge.
REQ-018 In RUN each edge SHALL perform one op_r step regardless of en, op, sd changes on op? (fill bit sd sampled live each step), decrement cnt; on edge where cnt==1 the final step executes, state->IDLE, busy<=0, done<=1.
REQ-019 busy SHALL be high exactly len cycles; done SHALL be high exactly the one cycle following the final step.
REQ-020 start with len==0 in IDLE: no shift, no busy; done pulses one cycle after the accept edge.
REQ-021 start while busy SHALL be ignored (no restart, no extension).
REQ-022 len > WIDTH legal; steps continue (rotates wrap, shifts fill) for full count.
REQ-023 cnt SHALL be LENW bits, never underflow; op_r 000 burst runs len cycles with q unchanged.
REQ-024 en ignored while busy; start and en same edge in IDLE: start wins, no manual step.

Reset
REQ-025 reset_n=0 SHALL immediately force q=0, sout=0, busy=0, done=0, cnt=0, state IDLE, independent of clk.
REQ-026 Reset mid-burst SHALL abort burst with no done pulse; first edge after release behaves as IDLE.

Verification (WIDTH=8)
REQ-027 Load 8'hA5, then op=010, sd=1, en=1 one edge -> q=8'hD2, sout=1.
REQ-028 Load 8'h81, op=101, en=1 one edge -> q=8'hC0, sout=1; op=100 on 8'h01 -> q=8'h80, sout=1.
REQ-029 Load 8'h01, start=1 len=3 op=011 -> busy high 3 cycles, q=8'h02,8'h04,8'h08, done one pulse next cycle, busy low.
REQ-030 Burst len=10 op=110 on 8'hFF -> q=8'h00 after 8 steps, busy still high 2 more cycles, then done.
REQ-031 Burst len=5 running; ld=1 d=8'h3C on step 2 -> q=8'h3C, busy=0, no done; start at len=0 -> done pulse, q unchanged.
REQ-032 Assert reset_n=0 mid-burst between edges -> q=0, busy=0, done=0 immediately; no done after release.
